// File: rtl/sim_sync_fifo_pkg.sv
// sim_sync_fifo_pkg: shared helpers for the simulation FIFO model and its RAM.
//   log2_ceil        - address width for a given depth
//   is_pow2          - power-of-two test for DEPTH
//   fifo_params_ok   - legality of WIDTH / DEPTH / threshold combination
package sim_sync_fifo_pkg;

   localparam int unsigned MIN_WIDTH = 1;
   localparam int unsigned MAX_WIDTH = 32;
   localparam int unsigned MIN_DEPTH = 2;
   localparam int unsigned MAX_DEPTH = 4096;

   function automatic int unsigned log2_ceil(input int unsigned val);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(val)) res = i + 1;
      end
      return res;
   endfunction

   function automatic bit is_pow2(input int unsigned val);
      return (val != 0) && ((val & (val - 1)) == 0);
   endfunction

   // Thresholds are compared against COUNT, which never exceeds DEPTH, so
   // anything larger would be unreachable (or wrap when truncated).
   function automatic bit fifo_params_ok(input int unsigned width, input int unsigned depth,
                                         input int unsigned af, input int unsigned ae);
      return (width >= MIN_WIDTH) && (width <= MAX_WIDTH) &&
             (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) && is_pow2(depth) &&
             (af <= depth) && (ae <= depth);
   endfunction

endpackage

// File: rtl/sim_ram_1c.sv
// sim_ram_1c: single-clock block-RAM model, synchronous write, registered read.
//   C      clock
//   WE     write enable; WDATA stored at WADDR on posedge C
//   RE     read enable; RDATA <= mem[RADDR] on posedge C, holds otherwise
// Contents are never cleared; the read register has no reset.
module sim_ram_1c
   import sim_sync_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 512
) (
   input  logic                          C,
   input  logic                          WE,
   input  logic [log2_ceil(DEPTH)-1:0]   WADDR,
   input  logic [WIDTH-1:0]              WDATA,
   input  logic                          RE,
   input  logic [log2_ceil(DEPTH)-1:0]   RADDR,
   output logic [WIDTH-1:0]              RDATA
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge C) begin
      if (WE) r_mem[WADDR] <= WDATA;
   end

   always_ff @(posedge C) begin
      if (RE) RDATA <= r_mem[RADDR];
   end

endmodule

// File: rtl/sim_sync_fifo.sv
// sim_sync_fifo: single-clock FIFO model with ice40 BRAM semantics.
//   C, R        clock; synchronous active-low reset
//   W_EN/W_DATA write request, accepted iff !FULL
//   R_EN        pop request, accepted iff !EMPTY
//   R_DATA      registered read data (FWFT=1: head word whenever !EMPTY)
//   FULL/AFULL/EMPTY/AEMPTY  registered status flags
//   COUNT       words held (FWFT=1 includes the output-register word)
//   OVF/UDF     sticky rejected-write / rejected-read flags, cleared by reset
module sim_sync_fifo
   import sim_sync_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 512,
   parameter int unsigned AF_THRESH = DEPTH - 4,
   parameter int unsigned AE_THRESH = 4,
   parameter int unsigned FWFT      = 0
) (
   input  logic                        C,
   input  logic                        R,
   input  logic                        W_EN,
   input  logic [WIDTH-1:0]            W_DATA,
   input  logic                        R_EN,
   output logic [WIDTH-1:0]            R_DATA,
   output logic                        FULL,
   output logic                        AFULL,
   output logic                        EMPTY,
   output logic                        AEMPTY,
   output logic [log2_ceil(DEPTH):0]   COUNT,
   output logic                        OVF,
   output logic                        UDF
);

   localparam int unsigned PW = log2_ceil(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
   localparam bit IS_FWFT = (FWFT != 0);

   if (!fifo_params_ok(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
      $error("sim_sync_fifo: illegal WIDTH=%0d DEPTH=%0d AF_THRESH=%0d AE_THRESH=%0d",
             WIDTH, DEPTH, AF_THRESH, AE_THRESH);
   end

   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             r_full;
   logic             r_afull;
   logic             r_empty;
   logic             r_aempty;
   logic             r_ovf;
   logic             r_udf;
   logic             r_valid;
   logic             r_loaded;

   logic             w_wr_acc;
   logic             w_rd_acc;
   logic [CW-1:0]    w_mem_cnt;
   logic             w_prefetch;
   logic             w_ram_re;
   logic [CW-1:0]    w_count_d;
   logic             w_valid_d;
   logic             w_empty_d;
   logic [WIDTH-1:0] w_ram_rdata;

   always_comb begin
      w_wr_acc   = W_EN & ~r_full;
      w_rd_acc   = R_EN & ~r_empty;
      // Words still in memory; in FWFT mode one word may sit in the output register.
      w_mem_cnt  = r_count - CW'(r_valid);
      w_prefetch = IS_FWFT && (!r_valid || w_rd_acc) && (w_mem_cnt != '0);
      w_ram_re   = IS_FWFT ? w_prefetch : w_rd_acc;
      w_count_d  = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
      w_valid_d  = IS_FWFT && (w_prefetch || (r_valid && !w_rd_acc));
      w_empty_d  = IS_FWFT ? !w_valid_d : (w_count_d == '0);
   end

   always_ff @(posedge C) begin
      if (!R) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
         r_empty  <= 1'b1;
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
         r_valid  <= 1'b0;
         r_loaded <= 1'b0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + PW'(1);
         if (w_ram_re) begin
            r_rptr   <= r_rptr + PW'(1);
            r_loaded <= 1'b1;
         end
         r_count  <= w_count_d;
         r_full   <= (w_count_d == DEPTH_C);
         r_afull  <= (w_count_d >= AF_C);
         r_aempty <= (w_count_d <= AE_C);
         r_empty  <= w_empty_d;
         r_valid  <= w_valid_d;
         if (W_EN && r_full)  r_ovf <= 1'b1;
         if (R_EN && r_empty) r_udf <= 1'b1;
      end
   end

   // A read and a write never hit the same address on one edge: that needs
   // memory both empty (no read) and full (no write) at once.
   sim_ram_1c #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .C     (C),
      .WE    (w_wr_acc & R),
      .WADDR (r_wptr),
      .WDATA (W_DATA),
      .RE    (w_ram_re & R),
      .RADDR (r_rptr),
      .RDATA (w_ram_rdata)
   );

   // The RAM read register has no reset; mask it until the first load after
   // reset so R_DATA comes out of reset as zero.
   assign R_DATA = r_loaded ? w_ram_rdata : '0;
   assign FULL   = r_full;
   assign AFULL  = r_afull;
   assign EMPTY  = r_empty;
   assign AEMPTY = r_aempty;
   assign COUNT  = r_count;
   assign OVF    = r_ovf;
   assign UDF    = r_udf;

endmodule

// File: tb/tb_sim_sync_fifo.sv
// Bench for sim_sync_fifo: one standard-read and one FWFT instance (DEPTH=8),
// directed steps followed by random traffic, every edge checked against
// queue-based reference models.
module tb_sim_sync_fifo;

   localparam int unsigned W  = 8;
   localparam int unsigned D  = 8;
   localparam int unsigned AF = D - 4;
   localparam int unsigned AE = 4;
   localparam int unsigned CW = 4;

   logic          c = 1'b0;
   logic          r;
   logic          we0, re0, we1, re1;
   logic [W-1:0]  wd0, wd1;
   logic [W-1:0]  rd0, rd1;
   logic          full0, afull0, empty0, aempty0, ovf0, udf0;
   logic          full1, afull1, empty1, aempty1, ovf1, udf1;
   logic [CW-1:0] cnt0, cnt1;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: standard FIFO is a queue plus the last popped word;
   // FWFT FIFO is a memory queue plus a head register with a valid bit.
   logic [W-1:0] q0[$];
   logic [W-1:0] m_rd0;
   bit           m_ovf0, m_udf0;
   logic [W-1:0] q1[$];
   logic [W-1:0] m_out1;
   bit           m_val1, m_ovf1, m_udf1;

   always #5 c = ~c;

   sim_sync_fifo #(
      .WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
   ) u_dut0 (
      .C(c), .R(r), .W_EN(we0), .W_DATA(wd0), .R_EN(re0), .R_DATA(rd0),
      .FULL(full0), .AFULL(afull0), .EMPTY(empty0), .AEMPTY(aempty0),
      .COUNT(cnt0), .OVF(ovf0), .UDF(udf0)
   );

   sim_sync_fifo #(
      .WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
   ) u_dut1 (
      .C(c), .R(r), .W_EN(we1), .W_DATA(wd1), .R_EN(re1), .R_DATA(rd1),
      .FULL(full1), .AFULL(afull1), .EMPTY(empty1), .AEMPTY(aempty1),
      .COUNT(cnt1), .OVF(ovf1), .UDF(udf1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int  n0;
      int  n1;
      bit  pop1;
      bit  pf1;
      if (!r) begin
         q0.delete();
         m_rd0  = '0;
         m_ovf0 = 1'b0;
         m_udf0 = 1'b0;
         q1.delete();
         m_out1 = '0;
         m_val1 = 1'b0;
         m_ovf1 = 1'b0;
         m_udf1 = 1'b0;
         return;
      end
      n0 = q0.size();
      if (we0 && n0 == D) m_ovf0 = 1'b1;
      if (re0 && n0 == 0) m_udf0 = 1'b1;
      if (re0 && n0 != 0) m_rd0 = q0.pop_front();
      if (we0 && n0 != D) q0.push_back(wd0);

      n1 = q1.size() + (m_val1 ? 1 : 0);
      if (we1 && n1 == D) m_ovf1 = 1'b1;
      if (re1 && !m_val1) m_udf1 = 1'b1;
      pop1 = re1 && m_val1;
      pf1  = (!m_val1 || pop1) && (q1.size() > 0);
      if (pf1) begin
         m_out1 = q1.pop_front();
         m_val1 = 1'b1;
      end else if (pop1) begin
         m_val1 = 1'b0;
      end
      if (we1 && n1 != D) q1.push_back(wd1);
   endtask

   task automatic check_all();
      int n0;
      int n1;
      n0 = q0.size();
      n1 = q1.size() + (m_val1 ? 1 : 0);
      chk("count0",  cnt0,    n0);
      chk("full0",   full0,   n0 == D);
      chk("afull0",  afull0,  n0 >= AF);
      chk("empty0",  empty0,  n0 == 0);
      chk("aempty0", aempty0, n0 <= AE);
      chk("ovf0",    ovf0,    m_ovf0);
      chk("udf0",    udf0,    m_udf0);
      chk("rdata0",  rd0,     m_rd0);
      chk("count1",  cnt1,    n1);
      chk("full1",   full1,   n1 == D);
      chk("afull1",  afull1,  n1 >= AF);
      chk("empty1",  empty1,  !m_val1);
      chk("aempty1", aempty1, n1 <= AE);
      chk("ovf1",    ovf1,    m_ovf1);
      chk("udf1",    udf1,    m_udf1);
      chk("rdata1",  rd1,     m_out1);
   endtask

   // Inputs change only 1 time unit after an edge, so they are stable at the next one.
   task automatic tick();
      @(posedge c);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      int wp;
      r   = 1'b0;
      we0 = 1'b0; re0 = 1'b0; wd0 = '0;
      we1 = 1'b0; re1 = 1'b0; wd1 = '0;

      // Reset for two edges
      tick();
      tick();
      chk("rst_count",  cnt0,    0);
      chk("rst_empty",  empty0,  1);
      chk("rst_aempty", aempty0, 1);
      chk("rst_full",   full0,   0);
      chk("rst_ovf",    ovf0,    0);
      chk("rst_udf",    udf0,    0);
      chk("rst_rdata",  rd0,     0);
      chk("rst_empty1", empty1,  1);
      r = 1'b1;

      // Fill to FULL, then one rejected write
      we0 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wd0 = W'(32'h11 + i);
         tick();
         if (i == 2) chk("afull_at3", afull0, 0);
         if (i == 3) chk("afull_at4", afull0, 1);
      end
      chk("full_at8", full0, 1);
      wd0 = 8'h99;
      tick();
      chk("ovf_set", ovf0, 1);
      chk("count_held", cnt0, 8);
      we0 = 1'b0;

      // Drain in order
      re0 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("drain_data", rd0, 32'h11 + i);
      end
      re0 = 1'b0;
      chk("drain_empty", empty0, 1);

      // Wrap-around with COUNT held at 3
      we0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wd0 = W'(32'h20 + i);
         tick();
      end
      re0 = 1'b1;
      for (int i = 0; i < 22; i++) begin
         wd0 = W'(32'h23 + i);
         tick();
         chk("wrap_data", rd0, 32'h20 + i);
         chk("wrap_count", cnt0, 3);
         chk("wrap_nofull", full0, 0);
      end
      we0 = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      re0 = 1'b0;

      // Simultaneous requests at FULL and at EMPTY
      r = 1'b0;
      tick();
      r = 1'b1;
      chk("sim_ovf_clr", ovf0, 0);
      we0 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wd0 = W'(32'h40 + i);
         tick();
      end
      re0 = 1'b1;
      wd0 = 8'hEE;
      tick();
      chk("sim_full_count", cnt0, 7);
      chk("sim_full_ovf", ovf0, 1);
      chk("sim_full_data", rd0, 8'h40);
      we0 = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("sim_drained", cnt0, 0);
      we0 = 1'b1;
      wd0 = 8'h5A;
      tick();
      chk("sim_empty_count", cnt0, 1);
      chk("sim_empty_udf", udf0, 1);
      we0 = 1'b0;
      tick();
      chk("sim_empty_data", rd0, 8'h5A);
      chk("sim_empty_count0", cnt0, 0);
      re0 = 1'b0;

      // FWFT: write into empty, head appears one edge later, then pop
      we1 = 1'b1;
      wd1 = 8'hA5;
      tick();
      chk("fwft_n_empty", empty1, 1);
      chk("fwft_n_count", cnt1, 1);
      we1 = 1'b0;
      tick();
      chk("fwft_n1_empty", empty1, 0);
      chk("fwft_n1_data", rd1, 8'hA5);
      re1 = 1'b1;
      tick();
      chk("fwft_pop_empty", empty1, 1);
      chk("fwft_pop_count", cnt1, 0);
      re1 = 1'b0;

      // Reset mid-stream with a write pending
      we0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wd0 = W'(32'h60 + i);
         tick();
      end
      chk("mid_count5", cnt0, 5);
      r   = 1'b0;
      wd0 = 8'h77;
      tick();
      chk("mid_count", cnt0, 0);
      chk("mid_empty", empty0, 1);
      chk("mid_ovf", ovf0, 0);
      chk("mid_udf", udf0, 0);
      r   = 1'b1;
      we0 = 1'b0;
      tick();
      chk("mid_ignored", cnt0, 0);
      chk("mid_rdata", rd0, 0);

      // Random traffic in three fill-bias phases, rare resets
      for (int p = 0; p < 3; p++) begin
         wp = (p == 0) ? 70 : ((p == 1) ? 50 : 30);
         for (int i = 0; i < 200; i++) begin
            r   = ($urandom_range(99) != 0);
            we0 = ($urandom_range(99) < wp);
            re0 = ($urandom_range(99) < 100 - wp);
            wd0 = W'($urandom);
            we1 = ($urandom_range(99) < wp);
            re1 = ($urandom_range(99) < 100 - wp);
            wd1 = W'($urandom);
            tick();
         end
      end
      r = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
